// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: fetch FSM states, PC-select codes, reset PC,
// opcode field position, NOP encoding and the opcode constants used so far.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  localparam int unsigned OpcodeMsb = 31;
  localparam int unsigned OpcodeLsb = 26;

  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam logic [5:0] OpRtype    = 6'b000000;
  localparam logic [5:0] OpAddi     = 6'b001000;
  localparam logic [5:0] OpLw       = 6'b100011;
  localparam logic [5:0] OpSw       = 6'b101011;
  localparam logic [5:0] OpSpecial2 = 6'b011100;

  typedef enum logic [1:0] {
    StFetch,
    StHold,
    StFault
  } fetch_state_e;

  typedef enum logic [1:0] {
    PcHold,
    PcInc,
    PcRedirect
  } pc_sel_e;

  function automatic logic [5:0] get_opcode(input logic [31:0] word);
    return word[OpcodeMsb:OpcodeLsb];
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/ready handshake between the fetch stage (master)
// and instruction memory (slave).
interface instr_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/ifetch_pc_reg.sv
// Program counter register with hold / +4 / redirect next-PC mux.
// Without IFETCH_ALIGN_CHECK_EN the redirect target is forced word-aligned.
module ifetch_pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  pc_sel_e     pc_sel,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] target;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign target = redirect_pc;
`else
  logic unused_lsb;
  assign unused_lsb = ^redirect_pc[1:0];
  assign target     = {redirect_pc[31:2], 2'b00};
`endif

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d = pc_q;
    unique case (pc_sel)
      PcInc:      pc_d = pc_plus4;
      PcRedirect: pc_d = target;
      default:    pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// MIPS instruction fetch stage: PC, imem request/ready handshake, instruction register.
// Optional misaligned-redirect fault enabled by IFETCH_ALIGN_CHECK_EN.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_fetch_if.master        imem,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  output logic [31:0]          instr,
  output logic [5:0]           opcode,
  output logic [31:0]          pc,
  output logic [31:0]          pc_plus4,
  output logic                 instr_valid,
  output logic                 fetch_fault,
  output logic [31:0]          fetch_count
);

  fetch_state_e state_q, state_d;
  pc_sel_e      pc_sel;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;
  logic [31:0]  count_q, count_d;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;
  logic misaligned;
  assign misaligned = |redirect_pc[1:0];
`endif

  ifetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .pc_sel      (pc_sel),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .pc_plus4    (pc_plus4)
  );

  always_comb begin
    state_d = state_q;
    pc_sel  = PcHold;
    instr_d = instr_q;
    valid_d = valid_q;
    count_d = count_q;
`ifdef IFETCH_ALIGN_CHECK_EN
    fault_d = fault_q;
`endif
    unique case (state_q)
      StFetch: begin
        // Redirect wins over a same-cycle response; that word is dropped.
        if (redirect) begin
          pc_sel  = PcRedirect;
          valid_d = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
          if (misaligned) begin
            fault_d = 1'b1;
            state_d = StFault;
          end
`endif
        end else if (imem.ready) begin
          instr_d = imem.rdata;
          valid_d = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        if (redirect) begin
          pc_sel  = PcRedirect;
          valid_d = 1'b0;
          state_d = StFetch;
`ifdef IFETCH_ALIGN_CHECK_EN
          if (misaligned) begin
            fault_d = 1'b1;
            state_d = StFault;
          end
`endif
        end else if (!stall) begin
          pc_sel  = PcInc;
          valid_d = 1'b0;
          count_d = count_q + 32'd1;
          state_d = StFetch;
        end
      end
      StFault: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = StFetch;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
      instr_q <= NOP;
      valid_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

  // Request drops immediately on reset so an in-flight handshake is abandoned.
  assign imem.req    = (state_q == StFetch) && !rst;
  assign imem.addr   = pc;
  assign instr       = instr_q;
  assign opcode      = get_opcode(instr_q);
  assign instr_valid = valid_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch: handshake, wait states, stall,
// redirect priority, PC wrap, alignment handling and asynchronous reset.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  int checks;
  int errors;

  instr_fetch_if imem_bus ();

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (imem_bus.master),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .opcode      (opcode),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid),
    .fetch_fault (fetch_fault),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    imem_bus.ready = 1'b0;
    imem_bus.rdata = 32'h0;

    // Reset state
    #1;
    chk("rst_req", {31'd0, imem_bus.req}, 32'd0);
    chk("rst_pc", pc, 32'h0040_0000);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("fetch0_req", {31'd0, imem_bus.req}, 32'd1);
    chk("fetch0_addr", imem_bus.addr, 32'h0040_0000);

    // Zero-wait fetch of ADDI then LW
    imem_bus.ready = 1'b1;
    imem_bus.rdata = 32'h2008_0005;
    step();
    imem_bus.ready = 1'b0;
    chk("addi_instr", instr, 32'h2008_0005);
    chk("addi_opcode", {26'd0, opcode}, {26'd0, 6'b001000});
    chk("addi_valid", {31'd0, instr_valid}, 32'd1);
    chk("addi_pc", pc, 32'h0040_0000);
    chk("addi_pc4", pc_plus4, 32'h0040_0004);
    chk("hold_req", {31'd0, imem_bus.req}, 32'd0);
    step();
    chk("adv1_pc", pc, 32'h0040_0004);
    chk("adv1_count", fetch_count, 32'd1);
    chk("adv1_valid", {31'd0, instr_valid}, 32'd0);
    imem_bus.ready = 1'b1;
    imem_bus.rdata = 32'h8D09_0004;
    step();
    imem_bus.ready = 1'b0;
    chk("lw_opcode", {26'd0, opcode}, {26'd0, 6'b100011});
    chk("lw_pc", pc, 32'h0040_0004);
    step();
    chk("adv2_count", fetch_count, 32'd2);
    chk("adv2_pc", pc, 32'h0040_0008);

    // Three wait states: request held four cycles at a stable address
    for (int i = 0; i < 3; i++) begin
      chk("wait_req", {31'd0, imem_bus.req}, 32'd1);
      chk("wait_addr", imem_bus.addr, 32'h0040_0008);
      chk("wait_valid", {31'd0, instr_valid}, 32'd0);
      step();
    end
    chk("wait4_req", {31'd0, imem_bus.req}, 32'd1);
    imem_bus.ready = 1'b1;
    imem_bus.rdata = 32'hAD2A_0008;
    step();
    imem_bus.ready = 1'b0;
    chk("sw_valid", {31'd0, instr_valid}, 32'd1);
    chk("sw_opcode", {26'd0, opcode}, {26'd0, 6'b101011});

    // Five stalled cycles in HOLD
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_instr", instr, 32'hAD2A_0008);
      chk("stall_pc", pc, 32'h0040_0008);
      chk("stall_req", {31'd0, imem_bus.req}, 32'd0);
      chk("stall_count", fetch_count, 32'd2);
    end
    stall = 1'b0;
    step();
    chk("unstall_pc", pc, 32'h0040_000C);
    chk("unstall_count", fetch_count, 32'd3);
    chk("unstall_req", {31'd0, imem_bus.req}, 32'd1);

    // Redirect during a stalled HOLD
    imem_bus.ready = 1'b1;
    imem_bus.rdata = 32'h7000_0000;
    step();
    imem_bus.ready = 1'b0;
    chk("sp2_opcode", {26'd0, opcode}, {26'd0, 6'b011100});
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h0040_0040;
    step();
    redirect = 1'b0;
    stall = 1'b0;
    chk("redir_addr", imem_bus.addr, 32'h0040_0040);
    chk("redir_req", {31'd0, imem_bus.req}, 32'd1);
    chk("redir_valid", {31'd0, instr_valid}, 32'd0);
    chk("redir_count", fetch_count, 32'd3);

    // Redirect in the same FETCH cycle as ready: response discarded
    imem_bus.ready = 1'b1;
    imem_bus.rdata = 32'h0000_0020;
    redirect = 1'b1;
    redirect_pc = 32'h0040_0080;
    step();
    imem_bus.ready = 1'b0;
    redirect = 1'b0;
    chk("race_addr", imem_bus.addr, 32'h0040_0080);
    chk("race_req", {31'd0, imem_bus.req}, 32'd1);
    chk("race_valid", {31'd0, instr_valid}, 32'd0);
    chk("race_instr", instr, 32'h7000_0000);
    chk("race_count", fetch_count, 32'd3);

    // pc_plus4 wraps modulo 2^32
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4, 32'h0000_0000);

    // Misaligned redirect target
    redirect = 1'b1;
    redirect_pc = 32'h0040_0042;
    step();
    redirect = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    imem_bus.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("fault_flag", {31'd0, fetch_fault}, 32'd1);
      chk("fault_req", {31'd0, imem_bus.req}, 32'd0);
      chk("fault_valid", {31'd0, instr_valid}, 32'd0);
      chk("fault_pc", pc, 32'h0040_0042);
      step();
    end
    imem_bus.ready = 1'b0;
`else
    chk("align_addr", imem_bus.addr, 32'h0040_0040);
    chk("align_fault", {31'd0, fetch_fault}, 32'd0);
    chk("align_req", {31'd0, imem_bus.req}, 32'd1);
`endif

    // Asynchronous reset mid-cycle, then a fresh fetch from RESET_PC
    rst = 1'b1;
    #1;
    chk("arst_req", {31'd0, imem_bus.req}, 32'd0);
    chk("arst_pc", pc, 32'h0040_0000);
    chk("arst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("arst_count", fetch_count, 32'd0);
    chk("arst_instr", instr, 32'h0);
    step();
    rst = 1'b0;
    imem_bus.ready = 1'b1;
    imem_bus.rdata = 32'h8D09_0004;
    step();
    imem_bus.ready = 1'b0;
    chk("post_rst_instr", instr, 32'h8D09_0004);
    chk("post_rst_valid", {31'd0, instr_valid}, 32'd1);
    chk("post_rst_pc", pc, 32'h0040_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the MIPS datapath. Holds the program counter, requests instruction words from instruction memory over a request/ready handshake, and latches the fetched word into an instruction register. The register's opcode field (bits 31:26) drives the control unit; the full word feeds register-file addressing and immediate extension. The stage accepts stall and branch/jump redirect inputs from downstream.

## Interface
- RESET_PC, 32'h0040_0000, PC value loaded on reset (MARS text-segment base).
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  word address of the request; always equals pc.
- imem_ready  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  instruction word; valid only when imem_ready=1.
- stall  in  1  downstream cannot accept the next instruction; hold the current one.
- redirect  in  1  taken branch or jump; replace the PC.
- redirect_pc  in  32  target address for redirect.
- instr  out  32  instruction register.
- opcode  out  6  instr[31:26], wired to the control unit.
- pc  out  32  address of instr.
- pc_plus4  out  32  pc+4, combinational, wraps modulo 2^32.
- instr_valid  out  1  instr holds a fetched, non-squashed word.
- fetch_fault  out  1  sticky misaligned-target flag (see Configuration).
- fetch_count  out  32  number of instructions delivered (HOLD exits through advance), wraps.

## Operation
- States: FETCH, HOLD, FAULT.
- FETCH: imem_req=1 (forced 0 while rst=1); imem_addr=pc.
  - redirect=1: pc<=redirect_pc; stay in FETCH; any same-cycle imem_rdata is discarded. Redirect has priority over imem_ready.
  - else imem_ready=1: instr<=imem_rdata; instr_valid<=1; go to HOLD.
  - else stay; wait states are unbounded.
- HOLD: imem_req=0; instr and pc stable.
  - redirect=1: pc<=redirect_pc; instr_valid<=0; go to FETCH. Redirect overrides stall.
  - else stall=0: pc<=pc+4; instr_valid<=0; fetch_count<=fetch_count+1; go to FETCH.
  - else (stall=1): hold.
- FAULT: imem_req=0; instr_valid=0; only reset exits.
- stall in FETCH has no effect.
- Reset values: state=FETCH, pc=RESET_PC, instr=32'h0 (nop, opcode 0), instr_valid=0, fetch_fault=0, fetch_count=0. Reset mid-handshake abandons the request; a pending imem_ready after reset release is treated as a response to the RESET_PC request only if it arrives in a cycle when imem_req=1.

## Timing
- Zero-wait memory: imem_ready in the FETCH cycle, instr/instr_valid visible the next cycle; 2 cycles per instruction with no stall.
- N wait cycles add N cycles.
- Redirect-to-request latency: 1 cycle (new imem_addr visible the cycle after redirect is sampled).
- opcode and pc_plus4 are combinational from registered state; all other outputs are registered or decoded from state.

## Configuration
- IFETCH_ALIGN_CHECK_EN defined: a redirect with redirect_pc[1:0]!=0 sets fetch_fault<=1, instr_valid<=0, pc<=redirect_pc, and enters FAULT.
- Undefined: redirect_pc[1:0] is forced to 2'b00; fetch_fault is tied to 0; the FAULT state is unreachable.

## Structure
- Shared package mips_pkg: the fetch state enum, RESET_PC default, the opcode field position (31:26), the NOP encoding, and the existing opcode constants (R-type 000000, ADDI 001000, LW 100011, SW 101011, SPECIAL2 011100).
- One sub-module: ifetch_pc_reg. It contains the PC register, the next-PC mux (hold / +4 / redirect_pc), and the alignment masking.

## Test plan
- Reset, then imem_ready=1 every FETCH cycle with rdata 32'h2008_0005 (ADDI), 32'h8D09_0004 (LW) → pc sequence 0x00400000, 0x00400004; opcode 001000 then 100011; fetch_count=2 after the second advance.
- imem_ready delayed 3 cycles → imem_req held high 4 cycles, imem_addr stable, instr_valid rises the cycle after ready.
- stall=1 for 5 cycles in HOLD → instr and pc unchanged, imem_req=0; on release, pc +4 and fetch_count +1.
- redirect=1 with redirect_pc=0x00400040 in HOLD while stall=1 → next cycle imem_addr=0x00400040, instr_valid=0, fetch_count unchanged.
- redirect in the same FETCH cycle as imem_ready → rdata discarded, stays in FETCH at the target.
- IFETCH_ALIGN_CHECK_EN with redirect_pc=0x00400042 → fetch_fault=1 and imem_req=0 until rst; without the macro → imem_addr=0x00400040.
